mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction read) and the memory stage (data read/write).
- Sits between fetch/memoryblock and the memory macro.
- Serialises requests through a small FSM and gives priority to the data port, with a starvation guard for fetch.
- Produces per-port stall signals for the hazard logic.

Parameters:
DATA_WIDTH, 32, data and address width
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced a grant
TIMEOUT_CYCLES, 255, max cycles in a BUSY state without MemReady_i before abort

Ports:
clk  in  1  clock
rst  in  1  reset
IReq_i  in  1  fetch read request, held until IAck_o
IAddr_i  in  DATA_WIDTH  fetch address
IAck_o  out  1  one-cycle fetch completion pulse
IRData_o  out  DATA_WIDTH  fetched word, valid while IAck_o
DReq_i  in  1  data request, held until DAck_o
DWe_i  in  1  1=write, 0=read
DAddr_i  in  DATA_WIDTH  data address
DWData_i  in  DATA_WIDTH  write data
DByteEn_i  in  4  write byte enables
DAck_o  out  1  one-cycle data completion pulse
DRData_o  out  DATA_WIDTH  read data, valid while DAck_o
MemReq_o  out  1  memory request, held until MemReady_i
MemWe_o  out  1  memory write enable
MemAddr_o  out  DATA_WIDTH  memory address
MemWData_o  out  DATA_WIDTH  memory write data
MemByteEn_o  out  4  memory byte enables
MemRData_i  in  DATA_WIDTH  memory read data, valid with MemReady_i
MemReady_i  in  1  memory completion
StallF_o  out  1  IReq_i & ~IAck_o
StallM_o  out  1  DReq_i & ~DAck_o
Err_o  out  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: state IDLE. All outputs 0: MemReq_o, Mem* buses, both Ack_o, both RData_o, Err_o. Starvation and timeout counters 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE arbitration:
  - DReq_i only -> BUSY_D.
  - IReq_i only -> BUSY_I.
  - Both -> BUSY_D, unless starve_cnt == STARVE_LIMIT, then BUSY_I.
  - Neither -> stay IDLE.
- Request capture: on the grant edge, register MemReq_o=1 and the winner's address/we/wdata/byteen. Fetch grants always drive MemWe_o=0 and MemByteEn_o=0. Mem* outputs are held stable until MemReady_i.
- BUSY_x:
  - When MemReady_i=1, capture MemRData_i into the x RData register, drop MemReq_o next edge, go to RESP_x.
  - MemReady_i while in IDLE/RESP is ignored.
- RESP_x:
  - xAck_o=1 for exactly that cycle; RData is valid.
  - Requests are not sampled; next state is IDLE.
  - The requester must drop or renew its req the cycle after Ack.
- Latency: request present in IDLE at cycle N -> MemReq_o high at N+1. MemReady_i at cycle M (M>=N+1) -> Ack at M+1. Next arbitration at M+2.
- RData registers hold their last value between acks. Only a read transaction updates them; a write ack leaves DRData_o unchanged.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while IReq_i=1.
  - Clears on any I grant, and on any D grant made while IReq_i=0.
- Request withdrawal (flush): if the owning requester deasserts req while in BUSY_x, the memory transaction still completes (writes are not cancelled). The RESP_x cycle occurs with Ack suppressed, and RData is still updated.
- Timeout:
  - Counter runs in BUSY states and clears on state entry.
  - On reaching TIMEOUT_CYCLES without MemReady_i: drop MemReq_o, set Err_o (sticky until rst), go to RESP_x with Ack=1 and RData=0 so the pipeline does not deadlock.
- Reset mid-transaction: rst dominates. Return to IDLE, clear MemReq_o immediately on that edge, and no Ack is issued for the aborted transfer.
- Stalls: StallF_o and StallM_o are combinational from the req inputs and registered acks. There is no other combinational path from inputs to outputs.

Decomposition:
- Shared package riscv_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D}.
  - Localparam BYTEEN_ALL = 4'hF.
- No sub-module: the FSM, two counters and the capture registers stay in one module.

Test Plan:
1. I-only read: IReq_i=1, IAddr_i=0x100; memory returns MemReady_i two cycles after MemReq_o with data 0x00500093 -> MemAddr_o=0x100, MemWe_o=0, IAck_o one pulse with IRData_o=0x00500093, StallF_o low the cycle after ack.
2. Simultaneous request: IReq_i and DReq_i (write, DAddr_i=0x2000, DWData_i=0xDEADBEEF, DByteEn_i=0xF) in the same cycle -> D served first (MemWe_o=1, MemAddr_o=0x2000), then I served; StallF_o high throughout the D transaction.
3. Starvation: DReq_i held continuously with back-to-back reads, IReq_i high, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant, then D resumes.
4. Flush: after BUSY_I is entered, deassert IReq_i; MemReady_i arrives -> no IAck_o pulse, FSM returns to IDLE, the next D request is granted normally.
5. Timeout: TIMEOUT_CYCLES=8, MemReady_i never asserted on a D read -> MemReq_o drops after 8 cycles, DAck_o pulses with DRData_o=0, Err_o=1 and stays high until rst.
6. Reset mid-transaction: rst asserted for 1 cycle during BUSY_D -> next cycle MemReq_o=0, no DAck_o, state IDLE, Err_o=0, starvation count 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   BYTEEN_ALL  : full-word byte enable pattern
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch port (read only)
// and the data port (read/write). Data has priority, except that fetch is forced
// a grant once it has watched STARVE_LIMIT consecutive data grants go by. A stuck
// memory is aborted after TIMEOUT_CYCLES, which sets the sticky Err_o flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   IReq_i/IAddr_i      fetch request and address; IAck_o/IRData_o completion
//   DReq_i/DWe_i/...    data request, write enable, address, wdata, byte enables
//   DAck_o/DRData_o     data completion and read data
//   Mem*_o / Mem*_i     memory macro request side and completion side
//   StallF_o/StallM_o   per-port stalls for the hazard unit
//   Err_o               sticky timeout flag
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IReq_i,
    input  logic [DATA_WIDTH-1:0] IAddr_i,
    output logic                  IAck_o,
    output logic [DATA_WIDTH-1:0] IRData_o,
    input  logic                  DReq_i,
    input  logic                  DWe_i,
    input  logic [DATA_WIDTH-1:0] DAddr_i,
    input  logic [DATA_WIDTH-1:0] DWData_i,
    input  logic [3:0]            DByteEn_i,
    output logic                  DAck_o,
    output logic [DATA_WIDTH-1:0] DRData_o,
    output logic                  MemReq_o,
    output logic                  MemWe_o,
    output logic [DATA_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0] MemWData_o,
    output logic [3:0]            MemByteEn_o,
    input  logic [DATA_WIDTH-1:0] MemRData_i,
    input  logic                  MemReady_i,
    output logic                  StallF_o,
    output logic                  StallM_o,
    output logic                  Err_o
);

    localparam int unsigned StarveW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [StarveW-1:0]  StarveMax   = StarveW'(STARVE_LIMIT);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    arb_state_t          state;
    logic [StarveW-1:0]  starveCnt;
    logic [TimeoutW-1:0] timeoutCnt;
    logic                withdrawn;   // owner dropped its request during BUSY
    logic                forceFetch;

    assign forceFetch = IReq_i && (starveCnt == StarveMax);

    assign StallF_o = IReq_i & ~IAck_o;
    assign StallM_o = DReq_i & ~DAck_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starveCnt   <= '0;
            timeoutCnt  <= '0;
            withdrawn   <= 1'b0;
            MemReq_o    <= 1'b0;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= '0;
            MemWData_o  <= '0;
            MemByteEn_o <= '0;
            IAck_o      <= 1'b0;
            DAck_o      <= 1'b0;
            IRData_o    <= '0;
            DRData_o    <= '0;
            Err_o       <= 1'b0;
        end else begin
            IAck_o <= 1'b0;
            DAck_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    timeoutCnt <= '0;
                    withdrawn  <= 1'b0;
                    if (DReq_i && !forceFetch) begin
                        state       <= BUSY_D;
                        MemReq_o    <= 1'b1;
                        MemWe_o     <= DWe_i;
                        MemAddr_o   <= DAddr_i;
                        MemWData_o  <= DWData_i;
                        MemByteEn_o <= DByteEn_i;
                        // Count only data grants that made fetch wait.
                        if (!IReq_i) begin
                            starveCnt <= '0;
                        end else if (starveCnt != StarveMax) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
                    end else if (IReq_i) begin
                        state       <= BUSY_I;
                        MemReq_o    <= 1'b1;
                        MemWe_o     <= 1'b0;
                        MemAddr_o   <= IAddr_i;
                        MemWData_o  <= '0;
                        MemByteEn_o <= '0;
                        starveCnt   <= '0;
                    end
                end
                BUSY_I: begin
                    if (!IReq_i) withdrawn <= 1'b1;
                    if (MemReady_i) begin
                        MemReq_o <= 1'b0;
                        IRData_o <= MemRData_i;
                        IAck_o   <= IReq_i && !withdrawn;
                        state    <= RESP_I;
                    end else if (timeoutCnt == TimeoutLast) begin
                        MemReq_o <= 1'b0;
                        Err_o    <= 1'b1;
                        IRData_o <= '0;
                        IAck_o   <= IReq_i && !withdrawn;
                        state    <= RESP_I;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                BUSY_D: begin
                    if (!DReq_i) withdrawn <= 1'b1;
                    if (MemReady_i) begin
                        MemReq_o <= 1'b0;
                        // Write acks leave the last read data visible.
                        if (!MemWe_o) DRData_o <= MemRData_i;
                        DAck_o   <= DReq_i && !withdrawn;
                        state    <= RESP_D;
                    end else if (timeoutCnt == TimeoutLast) begin
                        MemReq_o <= 1'b0;
                        Err_o    <= 1'b1;
                        DRData_o <= '0;
                        DAck_o   <= DReq_i && !withdrawn;
                        state    <= RESP_D;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        IReq_i;
    logic [31:0] IAddr_i;
    logic        IAck_o;
    logic [31:0] IRData_o;
    logic        DReq_i;
    logic        DWe_i;
    logic [31:0] DAddr_i;
    logic [31:0] DWData_i;
    logic [3:0]  DByteEn_i;
    logic        DAck_o;
    logic [31:0] DRData_o;
    logic        MemReq_o;
    logic        MemWe_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWData_o;
    logic [3:0]  MemByteEn_o;
    logic [31:0] MemRData_i;
    logic        MemReady_i;
    logic        StallF_o;
    logic        StallM_o;
    logic        Err_o;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .IReq_i     (IReq_i),
        .IAddr_i    (IAddr_i),
        .IAck_o     (IAck_o),
        .IRData_o   (IRData_o),
        .DReq_i     (DReq_i),
        .DWe_i      (DWe_i),
        .DAddr_i    (DAddr_i),
        .DWData_i   (DWData_i),
        .DByteEn_i  (DByteEn_i),
        .DAck_o     (DAck_o),
        .DRData_o   (DRData_o),
        .MemReq_o   (MemReq_o),
        .MemWe_o    (MemWe_o),
        .MemAddr_o  (MemAddr_o),
        .MemWData_o (MemWData_o),
        .MemByteEn_o(MemByteEn_o),
        .MemRData_i (MemRData_i),
        .MemReady_i (MemReady_i),
        .StallF_o   (StallF_o),
        .StallM_o   (StallM_o),
        .Err_o      (Err_o)
    );

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [5:0] expIsFetch;

    initial begin
        rst = 1'b1; IReq_i = 1'b0; IAddr_i = '0; DReq_i = 1'b0; DWe_i = 1'b0;
        DAddr_i = '0; DWData_i = '0; DByteEn_i = '0; MemRData_i = '0; MemReady_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_memreq", {31'd0, MemReq_o}, 32'd0);
        chk("rst_iack",   {31'd0, IAck_o}, 32'd0);
        chk("rst_dack",   {31'd0, DAck_o}, 32'd0);
        chk("rst_err",    {31'd0, Err_o}, 32'd0);
        chk("rst_irdata", IRData_o, 32'd0);
        chk("rst_drdata", DRData_o, 32'd0);
        chk("rst_memaddr", MemAddr_o, 32'd0);

        // 1. Fetch-only read, memory ready two cycles after MemReq_o
        IReq_i = 1'b1; IAddr_i = 32'h100;
        tick();
        chk("t1_memreq",  {31'd0, MemReq_o}, 32'd1);
        chk("t1_memaddr", MemAddr_o, 32'h100);
        chk("t1_memwe",   {31'd0, MemWe_o}, 32'd0);
        chk("t1_byteen",  {28'd0, MemByteEn_o}, 32'd0);
        chk("t1_stallf",  {31'd0, StallF_o}, 32'd1);
        tick();
        chk("t1_memreq_hold", {31'd0, MemReq_o}, 32'd1);
        MemReady_i = 1'b1; MemRData_i = 32'h00500093;
        tick();
        MemReady_i = 1'b0;
        chk("t1_iack",   {31'd0, IAck_o}, 32'd1);
        chk("t1_irdata", IRData_o, 32'h00500093);
        chk("t1_memreq_drop", {31'd0, MemReq_o}, 32'd0);
        chk("t1_stallf_ack", {31'd0, StallF_o}, 32'd0);
        IReq_i = 1'b0;
        tick();
        chk("t1_iack_once", {31'd0, IAck_o}, 32'd0);
        chk("t1_stallf_after", {31'd0, StallF_o}, 32'd0);
        chk("t1_irdata_hold", IRData_o, 32'h00500093);

        // 2. Simultaneous fetch and data write: data first, then fetch
        IReq_i = 1'b1; IAddr_i = 32'h104;
        DReq_i = 1'b1; DWe_i = 1'b1; DAddr_i = 32'h2000; DWData_i = 32'hDEADBEEF;
        DByteEn_i = BYTEEN_ALL;
        tick();
        chk("t2_memreq",  {31'd0, MemReq_o}, 32'd1);
        chk("t2_memwe",   {31'd0, MemWe_o}, 32'd1);
        chk("t2_memaddr", MemAddr_o, 32'h2000);
        chk("t2_wdata",   MemWData_o, 32'hDEADBEEF);
        chk("t2_byteen",  {28'd0, MemByteEn_o}, 32'hF);
        chk("t2_stallf",  {31'd0, StallF_o}, 32'd1);
        chk("t2_stallm",  {31'd0, StallM_o}, 32'd1);
        MemReady_i = 1'b1; MemRData_i = 32'h12345678;
        tick();
        MemReady_i = 1'b0;
        chk("t2_dack",    {31'd0, DAck_o}, 32'd1);
        chk("t2_drdata_write_keeps", DRData_o, 32'd0);
        chk("t2_stallf_resp", {31'd0, StallF_o}, 32'd1);
        DReq_i = 1'b0; DWe_i = 1'b0;
        tick();
        chk("t2_idle_memreq", {31'd0, MemReq_o}, 32'd0);
        tick();
        chk("t2_i_memreq",  {31'd0, MemReq_o}, 32'd1);
        chk("t2_i_memaddr", MemAddr_o, 32'h104);
        chk("t2_i_memwe",   {31'd0, MemWe_o}, 32'd0);
        chk("t2_i_byteen",  {28'd0, MemByteEn_o}, 32'd0);
        MemReady_i = 1'b1; MemRData_i = 32'hA5A5A5A5;
        tick();
        MemReady_i = 1'b0;
        chk("t2_iack",   {31'd0, IAck_o}, 32'd1);
        chk("t2_irdata", IRData_o, 32'hA5A5A5A5);
        IReq_i = 1'b0;
        tick();

        // 3. Starvation: D D D D, then forced I, then D resumes
        expIsFetch = 6'b010000;
        IReq_i = 1'b1; IAddr_i = 32'h200;
        DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h3000;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("t3_memreq_%0d", g), {31'd0, MemReq_o}, 32'd1);
            chk($sformatf("t3_addr_%0d", g), MemAddr_o,
                expIsFetch[g] ? 32'h200 : 32'h3000);
            MemReady_i = 1'b1; MemRData_i = 32'h1000 + g;
            tick();
            MemReady_i = 1'b0;
            if (expIsFetch[g]) begin
                chk($sformatf("t3_iack_%0d", g), {31'd0, IAck_o}, 32'd1);
                chk($sformatf("t3_irdata_%0d", g), IRData_o, 32'h1000 + g);
                IReq_i = 1'b0;
            end else begin
                chk($sformatf("t3_dack_%0d", g), {31'd0, DAck_o}, 32'd1);
                chk($sformatf("t3_drdata_%0d", g), DRData_o, 32'h1000 + g);
            end
            tick();
        end
        DReq_i = 1'b0;
        tick();

        // 4. Fetch withdraws during BUSY_I: no ack, data then granted normally
        IReq_i = 1'b1; IAddr_i = 32'h300;
        tick();
        chk("t4_memaddr", MemAddr_o, 32'h300);
        IReq_i = 1'b0;
        tick();
        MemReady_i = 1'b1; MemRData_i = 32'hCAFEF00D;
        tick();
        MemReady_i = 1'b0;
        chk("t4_no_iack", {31'd0, IAck_o}, 32'd0);
        chk("t4_irdata",  IRData_o, 32'hCAFEF00D);
        DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h4000;
        tick();
        chk("t4_idle_memreq", {31'd0, MemReq_o}, 32'd0);
        chk("t4_no_iack2",    {31'd0, IAck_o}, 32'd0);
        tick();
        chk("t4_d_memreq",  {31'd0, MemReq_o}, 32'd1);
        chk("t4_d_memaddr", MemAddr_o, 32'h4000);
        MemReady_i = 1'b1; MemRData_i = 32'h11112222;
        tick();
        MemReady_i = 1'b0;
        chk("t4_dack",   {31'd0, DAck_o}, 32'd1);
        chk("t4_drdata", DRData_o, 32'h11112222);
        DReq_i = 1'b0;
        tick();

        // 5. Timeout on a data read: 8 BUSY cycles, then aborted ack with zero data
        DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h5000;
        tick();
        chk("t5_memreq_1", {31'd0, MemReq_o}, 32'd1);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("t5_memreq_%0d", c), {31'd0, MemReq_o}, 32'd1);
        end
        chk("t5_err_before", {31'd0, Err_o}, 32'd0);
        tick();
        chk("t5_memreq_drop", {31'd0, MemReq_o}, 32'd0);
        chk("t5_dack",   {31'd0, DAck_o}, 32'd1);
        chk("t5_drdata", DRData_o, 32'd0);
        chk("t5_err",    {31'd0, Err_o}, 32'd1);
        DReq_i = 1'b0;
        tick();
        tick();
        chk("t5_err_sticky", {31'd0, Err_o}, 32'd1);
        chk("t5_dack_once",  {31'd0, DAck_o}, 32'd0);

        // 6. Reset during BUSY_D
        DReq_i = 1'b1; DWe_i = 1'b1; DAddr_i = 32'h6000; DWData_i = 32'h55AA55AA;
        tick();
        chk("t6_memreq", {31'd0, MemReq_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; DReq_i = 1'b0;
        chk("t6_memreq_cleared", {31'd0, MemReq_o}, 32'd0);
        chk("t6_no_dack", {31'd0, DAck_o}, 32'd0);
        chk("t6_err_cleared", {31'd0, Err_o}, 32'd0);
        chk("t6_irdata_cleared", IRData_o, 32'd0);
        chk("t6_memaddr_cleared", MemAddr_o, 32'd0);
        MemReady_i = 1'b1; MemRData_i = 32'h77777777;
        tick();
        MemReady_i = 1'b0;
        chk("t6_ready_ignored_dack", {31'd0, DAck_o}, 32'd0);
        chk("t6_ready_ignored_drdata", DRData_o, 32'd0);
        chk("t6_idle_memreq", {31'd0, MemReq_o}, 32'd0);
        // Starve count is back at zero: with both requesting, data still wins.
        IReq_i = 1'b1; IAddr_i = 32'h700; DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h7000;
        tick();
        chk("t6_after_rst_dgrant", MemAddr_o, 32'h7000);
        IReq_i = 1'b0; DReq_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
